prf_wb_arbiter: RTL
===================

// Module: prf_wb_arbiter
// PURPOSE
//   Shares the single physical-register-file write port among N completing
//   execution units (ALU, LSU, BRU, ...). Each unit has one holding slot.
//   Occupied slots are granted round-robin, one per cycle, and drive a
//   registered write (write_en/pd_out/data_out) into phys_reg_file.
//   The same write doubles as the wakeup/busy-clear broadcast.
// PARAMETERS
//   N_REQ    3   number of requesting units (>=2)
//   XLEN     32  data width
//   PD_W     8   physical register index width (128 PRs used)
//   DROP_P0  1   1: writes to pd==0 are accepted and discarded (p0 is constant zero)
// PORTS
//   clk        in   1           clock
//   reset      in   1           synchronous, active-high
//   flush      in   1           mispredict/recovery: drop all pending writes
//   req_valid  in   N_REQ       unit i presents a result
//   req_pd     in   N_REQ*PD_W  destination PR per unit (unit i at [i*PD_W +: PD_W])
//   req_data   in   N_REQ*XLEN  result per unit
//   req_ready  out  N_REQ       slot i can accept this cycle
//   write_en   out  1           PRF write strobe (registered)
//   pd_out     out  PD_W        PRF write index (registered)
//   data_out   out  XLEN        PRF write data (registered)
//   grant_id   out  $clog2(N_REQ)  unit whose value is on data_out (registered)
//   idle       out  1           no slot occupied and write_en==0
// BEHAVIOUR
//   - Reset: occ=0, rr_ptr=0, write_en=0, pd_out=0, data_out=0, grant_id=0; idle=1.
//   - Handshake: accept_i = req_valid[i] & req_ready[i] & !flush.
//     On accept the slot loads {pd,data} at the edge; occ[i]=1 next cycle.
//     If DROP_P0 && req_pd_i==0, the accept completes but occ stays 0.
//   - req_ready[i] = !flush & (!occ[i] | grant[i]). A slot granted this cycle
//     can be refilled at the same edge, so an uncontended unit sustains
//     1 result/cycle.
//   - Arbitration (combinational): scan occ starting at rr_ptr and wrapping;
//     the first occupied slot gets one-hot grant. No grant if occ==0.
//   - On grant g (and no flush): write_en<=1, pd_out<=slot_pd[g],
//     data_out<=slot_data[g], grant_id<=g, occ[g] cleared (unless refilled),
//     rr_ptr<=(g+1) mod N_REQ. With no grant: write_en<=0, other outputs hold,
//     rr_ptr holds.
//   - Latency: accept at edge t -> write_en high in cycle t+1..t+2 window;
//     uncontended, write_en is high the cycle after the slot becomes occupied
//     (2 edges after req_valid is sampled).
//   - Worst-case wait for an occupied slot: N_REQ-1 grants (round-robin, no
//     starvation).
//   - flush: at that edge occ<=0 and write_en<=0; grants and accepts in the flush
//     cycle are discarded; rr_ptr holds. A write_en already high during the flush
//     cycle is a completed write and is not retracted.
//   - Simultaneous accept on all N_REQ slots is legal; they drain over N_REQ cycles.
//   - Reset mid-operation: all pending writes are lost; state returns to reset values.
//   - Widths: rr_ptr is $clog2(N_REQ) bits; the wrap is an explicit compare
//     against N_REQ-1, not overflow.
// STRUCTURE
//   - ooo_pkg: XLEN, PD_W, NUM_PREGS=128, typedef wb_req_t {pd, data}.
//   - Sub-module rr_arbiter #(N): inputs req, ptr; outputs one-hot grant, grant_idx;
//     purely combinational.
//   - Top: slot registers, occ vector, rr_ptr, output register.
// TESTING
//   1. Single write: unit0 valid, pd=5, data=0xDEADBEEF for one cycle ->
//      exactly one write_en pulse with pd_out=5, data_out=0xDEADBEEF,
//      grant_id=0, 2 edges later.
//   2. Contention: units 0,1,2 valid the same cycle (pd 10/11/12) ->
//      writes pd 10, 11, 12 on three consecutive cycles. Next triple -> order
//      continues from rr_ptr=0.
//   3. Streaming: unit1 valid every cycle, pd=20..27, others idle ->
//      req_ready[1] stays 1; 8 back-to-back writes in order.
//   4. Fairness: unit0 always valid, unit2 valid once -> unit2 is written within
//      2 cycles of occupancy; unit0 is never granted twice in a row while unit2
//      is pending.
//   5. p0 drop: DROP_P0=1, unit0 pd=0 data=0x1234 -> req_ready=1 and the accept
//      completes; write_en never rises.
//   6. Flush: 3 slots occupied, flush pulsed -> write_en=0 next cycle, no writes
//      afterwards, idle=1. Reset asserted with slots occupied -> all outputs at
//      reset values the next cycle.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core constants and the writeback request bundle.
// Imported by the PRF writeback arbiter and its round-robin picker.
package ooo_pkg;

   localparam int XLEN      = 32;
   localparam int PD_W      = 8;
   localparam int NUM_PREGS = 128;

   typedef struct packed {
      logic [PD_W-1:0] pd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping; one-hot grant plus its index.
module rr_arbiter
#(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
)
(
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] grant_idx_o
);

   import ooo_pkg::*;

   // One spare bit so ptr + offset never overflows before the wrap compare.
   logic [IW:0] idx;
   logic        found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, ptr_i} + (IW+1)'(k);
         if (idx >= (IW+1)'(N)) begin
            idx = idx - (IW+1)'(N);
         end
         if (!found && req_i[idx[IW-1:0]]) begin
            grant_o[idx[IW-1:0]] = 1'b1;
            grant_idx_o          = idx[IW-1:0];
            found                = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Physical register file writeback arbiter: one holding slot per unit,
// round-robin grant of occupied slots into a registered PRF write port.
module prf_wb_arbiter
#(
   parameter int N_REQ   = 3,
   parameter int XLEN    = ooo_pkg::XLEN,
   parameter int PD_W    = ooo_pkg::PD_W,
   parameter bit DROP_P0 = 1'b1
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*PD_W-1:0]    req_pd,
   input  logic [N_REQ*XLEN-1:0]    req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     write_en,
   output logic [PD_W-1:0]          pd_out,
   output logic [XLEN-1:0]          data_out,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     idle
);

   import ooo_pkg::*;

   localparam int IW = $clog2(N_REQ);

   logic [N_REQ-1:0] occ_q, occ_d;
   logic [PD_W-1:0]  slot_pd_q   [N_REQ];
   logic [XLEN-1:0]  slot_data_q [N_REQ];
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;

   logic             we_q, we_d;
   logic [PD_W-1:0]  pd_q, pd_d;
   logic [XLEN-1:0]  data_q, data_d;
   logic [IW-1:0]    gid_q, gid_d;

   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    grant_idx;
   logic [N_REQ-1:0] accept;
   logic [N_REQ-1:0] keep;
   logic             any_grant;

   rr_arbiter #(
      .N  (N_REQ),
      .IW (IW)
   ) u_rr (
      .req_i       (occ_q),
      .ptr_i       (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   assign any_grant = |occ_q;

   // A slot being granted this cycle is free again at the same edge.
   assign req_ready = {N_REQ{!flush}} & (~occ_q | grant);
   assign accept    = req_valid & req_ready;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         keep[i] = !(DROP_P0 && (req_pd[i*PD_W +: PD_W] == '0));
      end
   end

   always_comb begin
      occ_d = occ_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            occ_d[i] = 1'b0;
         end
         if (accept[i]) begin
            occ_d[i] = keep[i];
         end
      end
      if (flush) begin
         occ_d = '0;
      end
   end

   always_comb begin
      we_d     = 1'b0;
      pd_d     = pd_q;
      data_d   = data_q;
      gid_d    = gid_q;
      rr_ptr_d = rr_ptr_q;
      if (!flush && any_grant) begin
         we_d   = 1'b1;
         pd_d   = slot_pd_q[grant_idx];
         data_d = slot_data_q[grant_idx];
         gid_d  = grant_idx;
         if (grant_idx == IW'(N_REQ-1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_idx + IW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (accept[i]) begin
            slot_pd_q[i]   <= req_pd[i*PD_W +: PD_W];
            slot_data_q[i] <= req_data[i*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q    <= '0;
         rr_ptr_q <= '0;
         we_q     <= 1'b0;
         pd_q     <= '0;
         data_q   <= '0;
         gid_q    <= '0;
      end else begin
         occ_q    <= occ_d;
         rr_ptr_q <= rr_ptr_d;
         we_q     <= we_d;
         pd_q     <= pd_d;
         data_q   <= data_d;
         gid_q    <= gid_d;
      end
   end

   assign write_en = we_q;
   assign pd_out   = pd_q;
   assign data_out = data_q;
   assign grant_id = gid_q;
   assign idle     = (occ_q == '0) && !we_q;

endmodule
